// File: rtl/buffer_reg_skid.sv
// Registered valid/ready buffer with a one-entry skid slot, occupancy report and flush.
// Every output is registered so both the data path and the ready path are cut here.
module buffer_reg_skid #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] out_data_next;
  logic [WIDTH-1:0] skid_reg;
  logic [WIDTH-1:0] skid_next;
  logic             out_valid_reg;
  logic             in_ready_reg;
  logic [1:0]       occupancy_reg;
  logic             push;
  logic             pop;

  // Handshakes use the registered flags, so no combinational path crosses the buffer.
  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

  always_comb begin
    state_next    = state_reg;
    out_data_next = out_data_reg;
    skid_next     = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next    = BUSY;
            out_data_next = in_data;
          end
        end
        BUSY: begin
          if (push && !pop) begin
            state_next = FULL;
            skid_next  = in_data;
          end else if (pop && !push) begin
            state_next = EMPTY;
          end else if (push && pop) begin
            out_data_next = in_data;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_next    = BUSY;
            out_data_next = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Flags are decoded from the next state so they are exact one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      out_data_reg  <= RESET_DATA;
      skid_reg      <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      occupancy_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      out_data_reg  <= out_data_next;
      skid_reg      <= skid_next;
      out_valid_reg <= (state_next != EMPTY);
      in_ready_reg  <= (state_next != FULL);
      occupancy_reg <= occ_of(state_next);
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;
  assign occupancy = occupancy_reg;

endmodule
